// File: rtl/branch_ctrl.sv
// ============================================================================
// branch_ctrl: control-flow resolver feeding fetch_unit redirects, run control,
// ALU flag register and runaway watchdog. Optional macro: BRANCH_CTRL_FLAG_BYPASS_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_ctrl #(
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = '1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       is_branch,
  input  logic       is_jump,
  input  logic       is_halt,
  input  logic [1:0] br_cond,
  input  logic [3:0] imm_field,
  input  logic [5:0] tgt_field,
  input  logic       flag_we,
  input  logic       alu_z,
  input  logic       alu_n,
  output logic       branch_taken,
  output logic       jump_taken,
  output logic [3:0] branch_imm,
  output logic [5:0] jump_target,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                z_q, z_d;
  logic                n_q, n_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;

  logic                z_eff;
  logic                n_eff;
  logic                cond_true;
  logic                redirect_ok;

`ifdef BRANCH_CTRL_FLAG_BYPASS_EN
  // Compare-and-branch: a flag write in the branch's own cycle is seen directly.
  assign z_eff = flag_we ? alu_z : z_q;
  assign n_eff = flag_we ? alu_n : n_q;
`else
  assign z_eff = z_q;
  assign n_eff = n_q;
`endif

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = z_eff;
      2'b10:   cond_true = ~z_eff;
      default: cond_true = n_eff;
    endcase
  end

  // Halt suppresses any redirect issued alongside it.
  assign redirect_ok  = (state_q == RUN) && !is_halt;
  assign jump_taken   = redirect_ok && is_jump;
  assign branch_taken = redirect_ok && is_branch && !is_jump && cond_true;
  assign branch_imm   = imm_field;
  assign jump_target  = tgt_field;
  assign done         = done_q;
  assign timeout      = timeout_q;

  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    n_d       = n_q;
    wdog_d    = '0;
    done_d    = done_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        z_d       = 1'b0;
        n_d       = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        if (!start) state_d = RUN;
      end
      RUN: begin
        if (start) begin
          state_d = IDLE;
          z_d     = 1'b0;
          n_d     = 1'b0;
        end else begin
          if (flag_we) begin
            z_d = alu_z;
            n_d = alu_n;
          end
          // Halt takes priority over a watchdog expiry in the same cycle.
          if (is_halt) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (wdog_q == WDOG_LIMIT) begin
            state_d   = DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            wdog_d    = wdog_q;
          end else begin
            wdog_d = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d   = IDLE;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      wdog_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      n_q       <= n_d;
      wdog_q    <= wdog_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// tb_branch_ctrl: directed self-checking bench for branch_ctrl (WDOG_LIMIT=8).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       is_branch;
  logic       is_jump;
  logic       is_halt;
  logic [1:0] br_cond;
  logic [3:0] imm_field;
  logic [5:0] tgt_field;
  logic       flag_we;
  logic       alu_z;
  logic       alu_n;
  logic       branch_taken;
  logic       jump_taken;
  logic [3:0] branch_imm;
  logic [5:0] jump_target;
  logic       done;
  logic       timeout;

  int n_chk = 0;
  int n_bad = 0;

  branch_ctrl #(
    .WDOG_W     (16),
    .WDOG_LIMIT (16'd8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_branch    (is_branch),
    .is_jump      (is_jump),
    .is_halt      (is_halt),
    .br_cond      (br_cond),
    .imm_field    (imm_field),
    .tgt_field    (tgt_field),
    .flag_we      (flag_we),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .branch_taken (branch_taken),
    .jump_taken   (jump_taken),
    .branch_imm   (branch_imm),
    .jump_target  (jump_target),
    .done         (done),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dec();
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_halt   = 1'b0;
    br_cond   = 2'b00;
    imm_field = 4'h0;
    tgt_field = 6'd0;
    flag_we   = 1'b0;
    alu_z     = 1'b0;
    alu_n     = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    clr_dec();
    is_jump = 1'b1;
    #2;
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_timeout", {7'd0, timeout}, 8'd0);
    chk("rst_jump", {7'd0, jump_taken}, 8'd0);
    chk("rst_branch", {7'd0, branch_taken}, 8'd0);

    step();
    reset = 1'b1;
    step();
    chk("idle_jump", {7'd0, jump_taken}, 8'd0);

    // start falls: next edge enters RUN
    start = 1'b0;
    step();
    tgt_field = 6'd5;
    #1;
    chk("run_jump", {7'd0, jump_taken}, 8'd1);
    chk("run_jtgt", {2'd0, jump_target}, 8'd5);
    chk("run_jump_nobr", {7'd0, branch_taken}, 8'd0);

    // Z=1, N=0 registered
    clr_dec();
    flag_we = 1'b1; alu_z = 1'b1; alu_n = 1'b0;
    step();
    clr_dec();
    is_branch = 1'b1; br_cond = 2'b01; imm_field = 4'hE;
    #1;
    chk("br_zset", {7'd0, branch_taken}, 8'd1);
    chk("br_imm", {4'd0, branch_imm}, 8'h0E);
    br_cond = 2'b10; #1;
    chk("br_zclr", {7'd0, branch_taken}, 8'd0);
    br_cond = 2'b00; #1;
    chk("br_always", {7'd0, branch_taken}, 8'd1);
    br_cond = 2'b11; #1;
    chk("br_nset_n0", {7'd0, branch_taken}, 8'd0);

    // Z=0, N=1 registered
    clr_dec();
    flag_we = 1'b1; alu_z = 1'b0; alu_n = 1'b1;
    step();
    clr_dec();
    is_branch = 1'b1; br_cond = 2'b11;
    #1;
    chk("br_nset_n1", {7'd0, branch_taken}, 8'd1);
    br_cond = 2'b01; #1;
    chk("br_zset_z0", {7'd0, branch_taken}, 8'd0);

    // Same-cycle flag write with branch on Z (registered Z currently 0)
    flag_we = 1'b1; alu_z = 1'b1; alu_n = 1'b0; br_cond = 2'b01;
    #1;
`ifdef BRANCH_CTRL_FLAG_BYPASS_EN
    chk("br_bypass", {7'd0, branch_taken}, 8'd1);
`else
    chk("br_bypass", {7'd0, branch_taken}, 8'd0);
`endif
    step();
    clr_dec();
    is_branch = 1'b1; br_cond = 2'b01; #1;
    chk("br_after_we", {7'd0, branch_taken}, 8'd1);

    is_jump = 1'b1; #1;
    chk("bj_jump", {7'd0, jump_taken}, 8'd1);
    chk("bj_branch", {7'd0, branch_taken}, 8'd0);
    is_halt = 1'b1; #1;
    chk("hbj_jump", {7'd0, jump_taken}, 8'd0);
    chk("hbj_branch", {7'd0, branch_taken}, 8'd0);
    chk("hbj_done_pre", {7'd0, done}, 8'd0);
    step();
    chk("halt_done", {7'd0, done}, 8'd1);
    chk("halt_timeout", {7'd0, timeout}, 8'd0);
    chk("done_jump", {7'd0, jump_taken}, 8'd0);
    clr_dec();
    step();
    chk("done_hold", {7'd0, done}, 8'd1);

    // DONE -> IDLE clears flags; back to RUN and check Z cleared
    start = 1'b1;
    step();
    chk("done_clr", {7'd0, done}, 8'd0);
    start = 1'b0;
    step();
    is_branch = 1'b1; br_cond = 2'b10; #1;
    chk("idle_zclr", {7'd0, branch_taken}, 8'd1);

    // Set Z, then async reset mid-RUN with a jump in flight
    clr_dec();
    flag_we = 1'b1; alu_z = 1'b1;
    step();
    clr_dec();
    is_jump = 1'b1; #1;
    chk("pre_rst_jump", {7'd0, jump_taken}, 8'd1);
    reset = 1'b0; #1;
    chk("midrst_jump", {7'd0, jump_taken}, 8'd0);
    step();
    reset = 1'b1;
    clr_dec();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    is_branch = 1'b1; br_cond = 2'b01; #1;
    chk("midrst_z", {7'd0, branch_taken}, 8'd0);

    // Abort: start=1 in RUN -> IDLE, flags cleared
    clr_dec();
    flag_we = 1'b1; alu_z = 1'b1;
    start = 1'b1;
    step();
    clr_dec();
    is_jump = 1'b1; #1;
    chk("abort_jump", {7'd0, jump_taken}, 8'd0);
    start = 1'b0;
    clr_dec();
    step();
    is_branch = 1'b1; br_cond = 2'b01; #1;
    chk("abort_z", {7'd0, branch_taken}, 8'd0);

    // Watchdog: already in RUN with wdog advancing; restart cleanly
    clr_dec();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 8; i++) step();
    chk("wd_8_done", {7'd0, done}, 8'd0);
    step();
    chk("wd_9_done", {7'd0, done}, 8'd1);
    chk("wd_9_timeout", {7'd0, timeout}, 8'd1);
    start = 1'b1;
    step();
    chk("wd_clr_done", {7'd0, done}, 8'd0);
    chk("wd_clr_timeout", {7'd0, timeout}, 8'd0);

    // Halt coincident with watchdog limit: halt wins
    start = 1'b0;
    step();
    for (int i = 0; i < 8; i++) step();
    is_halt = 1'b1;
    step();
    chk("wdh_done", {7'd0, done}, 8'd1);
    chk("wdh_timeout", {7'd0, timeout}, 8'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
